// File: rtl/int_ctrl.sv
// Interrupt entry/exit sequencer: synchronizes a level request, saves context,
// vectors the PC, and restores PC and flags on return-from-interrupt.
module int_ctrl #(
  parameter logic [11:0] VECTOR = 12'h001
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        cen_i,
  input  logic        int_req_i,
  input  logic        boundary_i,
  input  logic        enai_i,
  input  logic        disi_i,
  input  logic        reti_i,
  input  logic [11:0] saved_pc_i,
  input  logic        saved_c_i,
  input  logic        saved_z_i,
  output logic        save_we_o,
  output logic        int_ack_o,
  output logic        pc_load_o,
  output logic [11:0] pc_val_o,
  output logic        flag_load_o,
  output logic        c_o,
  output logic        z_o,
  output logic        int_en_o,
  output logic        in_service_o
);

  // state     | meaning
  // S_IDLE    | no interrupt active; enai/disi update ie at boundaries
  // S_SAVE    | save register write + acknowledge; ie cleared on exit
  // S_VECTOR  | PC overwritten with VECTOR
  // S_SERVICE | handler running; waits for reti at a boundary
  // S_RESTORE | PC and flags reloaded from save register; ie set on exit
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_VECTOR,
    S_SERVICE,
    S_RESTORE
  } state_t;

  state_t state, state_nxt;
  logic   ie, ie_nxt;
  logic   req_s1, req_s2;

  // Synchronizer runs every edge so request latency does not depend on cen_i.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
    end else begin
      req_s1 <= int_req_i;
      req_s2 <= req_s1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      state <= S_IDLE;
      ie    <= 1'b0;
    end else if (cen_i) begin
      state <= state_nxt;
      ie    <= ie_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ie_nxt       = ie;
    save_we_o    = 1'b0;
    int_ack_o    = 1'b0;
    pc_load_o    = 1'b0;
    pc_val_o     = 12'h000;
    flag_load_o  = 1'b0;
    c_o          = 1'b0;
    z_o          = 1'b0;
    in_service_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (boundary_i) begin
          // disi has priority over enai when both decode in one instruction
          if (disi_i)      ie_nxt = 1'b0;
          else if (enai_i) ie_nxt = 1'b1;
          if (ie && req_s2 && !disi_i) state_nxt = S_SAVE;
        end
      end
      S_SAVE: begin
        save_we_o = 1'b1;
        int_ack_o = 1'b1;
        ie_nxt    = 1'b0;
        state_nxt = S_VECTOR;
      end
      S_VECTOR: begin
        pc_load_o = 1'b1;
        pc_val_o  = VECTOR;
        state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        in_service_o = 1'b1;
        if (boundary_i && reti_i) state_nxt = S_RESTORE;
      end
      S_RESTORE: begin
        pc_load_o   = 1'b1;
        pc_val_o    = saved_pc_i;
        flag_load_o = 1'b1;
        c_o         = saved_c_i;
        z_o         = saved_z_i;
        ie_nxt      = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign int_en_o = ie;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The module SHALL have parameter VECTOR, default 12'h001, meaning the PC value loaded on interrupt entry.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single rising-edge clock.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The module SHALL have port cen_i, input, 1 bit: processor clock enable; state advances only when it is 1.
REQ-005 The module SHALL have port int_req_i, input, 1 bit: external interrupt request, level-sensitive and asynchronous.
REQ-006 The module SHALL have port boundary_i, input, 1 bit: the current cycle is an instruction boundary.
REQ-007 The module SHALL have ports enai_i, disi_i and reti_i, input, 1 bit each: decoded enable, disable and return-from-interrupt instructions, valid when boundary_i=1.
REQ-008 The module SHALL have ports saved_pc_i (12 bits), saved_c_i (1 bit) and saved_z_i (1 bit), inputs: PC and flags held by the downstream interrupt save register.
REQ-009 The module SHALL have port save_we_o, output, 1 bit: write enable to the interrupt save register.
REQ-010 The module SHALL have port int_ack_o, output, 1 bit: interrupt acknowledge to the requester.
REQ-011 The module SHALL have ports pc_load_o (1 bit) and pc_val_o (12 bits), outputs: PC overwrite strobe and its value.
REQ-012 The module SHALL have ports flag_load_o, c_o and z_o, outputs, 1 bit each: flag restore strobe and restored values.
REQ-013 The module SHALL have ports int_en_o and in_service_o, outputs, 1 bit each: the interrupt-enable flag and "handler active".

Function
REQ-014 int_req_i SHALL pass through a 2-flop synchronizer clocked every clk_i edge, independent of cen_i.
REQ-015 The FSM SHALL have states IDLE, SAVE, VECTOR, SERVICE and RESTORE, and SHALL change state only on edges where cen_i=1.
REQ-016 IDLE -> SAVE SHALL occur when cen_i=1, boundary_i=1, ie=1, the synchronized request is 1, and disi_i=0.
REQ-017 SAVE SHALL drive save_we_o=1 and int_ack_o=1, clear ie, and then go to VECTOR.
REQ-018 VECTOR SHALL drive pc_load_o=1 with pc_val_o=VECTOR, and then go to SERVICE.
REQ-019 SERVICE SHALL drive in_service_o=1 and hold until cen_i=1, boundary_i=1 and reti_i=1, then go to RESTORE.
REQ-020 RESTORE SHALL drive pc_load_o=1 with pc_val_o=saved_pc_i, and flag_load_o=1 with c_o=saved_c_i and z_o=saved_z_i.
REQ-021 RESTORE SHALL set ie=1 and then go to IDLE.
REQ-022 Strobe outputs SHALL be Moore outputs decoded from the registered state, and SHALL stay asserted across cen_i=0 stall cycles so that consumers sample them on their cen-qualified edge.
REQ-023 In IDLE at a boundary, enai_i SHALL set ie and disi_i SHALL clear ie; if both are asserted, disi_i SHALL win.
REQ-024 enai_i and disi_i SHALL be ignored outside IDLE; there is no nesting.
REQ-025 reti_i in IDLE SHALL be ignored: no pc_load_o, no flag_load_o, and ie unchanged.
REQ-026 A request that drops before acceptance SHALL be lost; no latching beyond the synchronizer.
REQ-027 A request still high on RESTORE -> IDLE SHALL be re-accepted at the next qualifying boundary.
REQ-028 Minimum latency SHALL be 2 clk_i cycles for the synchronizer plus the first qualifying boundary edge to reach SAVE, then 1 cen edge to VECTOR.
REQ-029 When idle, pc_val_o SHALL be 12'h000.

Reset
REQ-030 When rst=0 on a clk_i edge, the module SHALL go to IDLE regardless of cen_i, clear ie and both synchronizer flops, and drive every output to 0.
REQ-031 Reset asserted mid-SAVE, mid-VECTOR, mid-SERVICE or mid-RESTORE SHALL abort the sequence with no residual strobe on the following cycle.

Verification
REQ-032 A bench SHALL cover basic entry: after enai_i, raise int_req_i with cen_i=1 and boundary_i held at 1 -> save_we_o/int_ack_o for 1 cycle, then pc_load_o with pc_val_o=12'h001, then in_service_o=1 and int_en_o=0.
REQ-033 A bench SHALL cover return: in SERVICE with saved_pc_i=12'h2A5, saved_c_i=1, saved_z_i=0, pulse reti_i at a boundary -> pc_val_o=12'h2A5, c_o=1, z_o=0 and int_en_o=1 next cycle.
REQ-034 A bench SHALL cover stall: hold cen_i=0 for 3 cycles during SAVE -> save_we_o stays 1 for all 3 cycles and the state does not advance.
REQ-035 A bench SHALL cover masking: disi_i with int_req_i high, and enai_i+disi_i together -> no SAVE, int_en_o=0; a later enai_i with the request still high -> SAVE.
REQ-036 A bench SHALL cover spurious reti and nesting: reti_i in IDLE -> no strobes; int_req_i toggling during SERVICE -> no second save_we_o.
REQ-037 A bench SHALL cover reset mid-VECTOR: rst=0 for 1 cycle -> all outputs 0 next cycle, and int_en_o=0 until enai_i.
